// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial NAND add/subtract unit.
//   state_t : controller states (IDLE, RUN, DONE)
//   OP_ADD  : op encoding for a + b
//   OP_SUB  : op encoding for a - b (computed as a + ~b + 1)
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_nand_if.sv
// Request/response bundle for the bit-serial add/subtract unit.
//   start  : request, only honoured while the unit is idle
//   op     : 0 = add, 1 = subtract, sampled with start
//   a, b   : operands, sampled with start
//   busy   : high from accepted start through the done cycle
//   done   : one-cycle pulse when result/cout/ovf have just been updated
//   result : sum or difference, held until the next completion
//   cout   : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    : two's-complement overflow
// master drives the request side, slave is the arithmetic unit.
interface serial_addsub_nand_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/fa_nand_cell.sv
// One-bit full adder built only from two-input NAND gates (nine of them).
//   i_a, i_b : addend bits
//   i_cin    : carry in
//   o_sum    : i_a ^ i_b ^ i_cin
//   o_cout   : majority(i_a, i_b, i_cin)
module fa_nand_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_n1, w_n2, w_n3, w_n4, w_n5, w_n6, w_n7;

  // First half adder: w_n4 is i_a ^ i_b, w_n1 is ~(i_a & i_b).
  nand g1 (w_n1, i_a, i_b);
  nand g2 (w_n2, i_a, w_n1);
  nand g3 (w_n3, i_b, w_n1);
  nand g4 (w_n4, w_n2, w_n3);

  // Second half adder folds in the carry; w_n5 is ~((a ^ b) & cin).
  nand g5 (w_n5, w_n4, i_cin);
  nand g6 (w_n6, w_n4, w_n5);
  nand g7 (w_n7, i_cin, w_n5);
  nand g8 (o_sum, w_n6, w_n7);

  // Carry out is (a & b) | ((a ^ b) & cin), i.e. NAND of the two inverted terms.
  nand g9 (o_cout, w_n1, w_n5);

endmodule

// File: rtl/serial_addsub_nand.sv
// Bit-serial add/subtract unit. A single NAND full-adder cell is reused
// for WIDTH clock cycles, LSB first. Subtraction runs as a + ~b + 1 by
// inverting B on load and seeding the carry with 1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears everything immediately
//   bus   : slave side of serial_addsub_nand_if (start/op/a/b in,
//           busy/done/result/cout/ovf out)
import serial_addsub_pkg::*;

module serial_addsub_nand #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_addsub_nand_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_cMsbIn;
  logic             w_cellSum;
  logic             w_cellCout;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_lastBit = (r_state == RUN) && (r_cnt == LAST_BIT);

  // While the MSB is being processed the carry flop holds the carry into
  // the MSB, which is exactly what the overflow rule needs.
  assign w_cMsbIn = r_carry;

  fa_nand_cell u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_cellSum),
    .o_cout (w_cellCout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: a start is only seen in IDLE; RUN lasts WIDTH cycles;
  // DONE is a single cycle and always returns to IDLE.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_cnt == LAST_BIT) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Serial datapath: load on accept, then one bit per RUN cycle. Sum bits
  // enter the accumulator from the MSB side so after WIDTH shifts bit 0
  // sits at the LSB. The visible outputs only move on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.op}};
      r_carry <= bus.op;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_acc   <= {w_cellSum, r_acc[WIDTH-1:1]};
      r_carry <= w_cellCout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_lastBit) begin
        r_result <= {w_cellSum, r_acc[WIDTH-1:1]};
        r_cout   <= w_cellCout;
        r_ovf    <= w_cellCout ^ w_cMsbIn;
      end
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub_nand.sv
// Self-checking bench for serial_addsub_nand. Drives a 4-bit and an 8-bit
// instance through serial_addsub_nand_if with directed vectors, a full
// 4-bit sweep against an arithmetic reference, start-held and mid-run
// reset scenarios.
module tb_serial_addsub_nand;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_addsub_nand_if #(.WIDTH(4)) bus4 ();
  serial_addsub_nand_if #(.WIDTH(8)) bus8 ();

  serial_addsub_nand #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  serial_addsub_nand #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // Compare one observed value with its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: {ovf, cout, result} packed at bits [w+1], [w], [w-1:0].
  function automatic logic [31:0] model(input int w, input logic op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, half, bb, full, low;
    logic        cIn, cOut;
    mask = (32'd1 << w) - 32'd1;
    half = mask >> 1;
    bb   = op ? (~b & mask) : (b & mask);
    full = (a & mask) + bb + {31'd0, op};
    low  = (a & half) + (bb & half) + {31'd0, op};
    cIn  = low[w-1];
    cOut = full[w];
    return (full & mask) | ({31'd0, cOut} << w) | ({31'd0, cOut ^ cIn} << (w + 1));
  endfunction

  // Present one request to the 4-bit unit ahead of the next rising edge.
  task automatic applyStimulus(input logic op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.op    = op;
    bus4.a     = a;
    bus4.b     = b;
  endtask

  // Run one 4-bit op and check timing, handshake and arithmetic.
  task automatic run4(input string tag, input logic op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] expRes,
                      input logic expCout, input logic expOvf);
    int         doneCount, doneAt, busyCount;
    logic [3:0] gotRes;
    logic       gotCout, gotOvf;
    doneCount = 0; doneAt = -1; busyCount = 0;
    gotRes = 'x; gotCout = 1'bx; gotOvf = 1'bx;
    applyStimulus(op, a, b);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (bus4.busy) busyCount++;
      if (bus4.done) begin
        doneCount++;
        if (doneAt < 0) begin
          doneAt  = i;
          gotRes  = bus4.result;
          gotCout = bus4.cout;
          gotOvf  = bus4.ovf;
        end
      end
    end
    checkOutput({tag, "/latency"}, doneAt, 4);
    checkOutput({tag, "/donePulses"}, doneCount, 1);
    checkOutput({tag, "/busyCycles"}, busyCount, 5);
    checkOutput({tag, "/result"}, {28'd0, gotRes}, {28'd0, expRes});
    checkOutput({tag, "/cout"}, {31'd0, gotCout}, {31'd0, expCout});
    checkOutput({tag, "/ovf"}, {31'd0, gotOvf}, {31'd0, expOvf});
  endtask

  // Run one 8-bit op and check it against the reference.
  task automatic run8(input string tag, input logic op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] expRes,
                      input logic expCout, input logic expOvf);
    int         doneCount, doneAt;
    logic [7:0] gotRes;
    logic       gotCout, gotOvf;
    doneCount = 0; doneAt = -1;
    gotRes = 'x; gotCout = 1'bx; gotOvf = 1'bx;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        doneCount++;
        if (doneAt < 0) begin
          doneAt  = i;
          gotRes  = bus8.result;
          gotCout = bus8.cout;
          gotOvf  = bus8.ovf;
        end
      end
    end
    checkOutput({tag, "/latency"}, doneAt, 8);
    checkOutput({tag, "/donePulses"}, doneCount, 1);
    checkOutput({tag, "/result"}, {24'd0, gotRes}, {24'd0, expRes});
    checkOutput({tag, "/cout"}, {31'd0, gotCout}, {31'd0, expCout});
    checkOutput({tag, "/ovf"}, {31'd0, gotOvf}, {31'd0, expOvf});
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    logic [31:0] e;
    rst_n      = 1'b0;
    bus4.start = 1'b0; bus4.op = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.op = 1'b0; bus8.a = '0; bus8.b = '0;
    #12;
    checkOutput("reset/busy", {31'd0, bus4.busy}, 32'd0);
    checkOutput("reset/done", {31'd0, bus4.done}, 32'd0);
    checkOutput("reset/result", {28'd0, bus4.result}, 32'd0);
    checkOutput("reset/cout", {31'd0, bus4.cout}, 32'd0);
    checkOutput("reset/ovf", {31'd0, bus4.ovf}, 32'd0);
    checkOutput("reset/busy8", {31'd0, bus8.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed 4-bit vectors.
    run4("add5p3", 1'b0, 4'h5, 4'h3, 4'h8, 1'b0, 1'b1);
    run4("sub3m5", 1'b1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0);
    run4("sub8m1", 1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1);
    run4("addFp1", 1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
    run4("sub0m0", 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Start held high with inputs churning: only the first op runs, the
    // next is taken six edges later and the first result holds until then.
    applyStimulus(1'b0, 4'h5, 4'h3);
    @(posedge clk); #1;
    checkOutput("held/busyAtStart", {31'd0, bus4.busy}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus4.a  = 4'($urandom);
      bus4.b  = 4'($urandom);
      bus4.op = ~bus4.op;
      @(posedge clk); #1;
      if (i == 4) begin
        checkOutput("held/done1", {31'd0, bus4.done}, 32'd1);
        checkOutput("held/result1", {28'd0, bus4.result}, 32'h8);
        checkOutput("held/ovf1", {31'd0, bus4.ovf}, 32'd1);
      end else if (i == 5) begin
        checkOutput("held/idleGap", {31'd0, bus4.busy}, 32'd0);
        checkOutput("held/result1Hold", {28'd0, bus4.result}, 32'h8);
      end else begin
        checkOutput("held/noEarlyDone", {31'd0, bus4.done}, 32'd0);
      end
    end
    @(negedge clk);
    bus4.op = 1'b1; bus4.a = 4'h9; bus4.b = 4'h2;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    checkOutput("held/secondAccepted", {31'd0, bus4.busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        checkOutput("held/result1Stable", {28'd0, bus4.result}, 32'h8);
        checkOutput("held/noDone2Yet", {31'd0, bus4.done}, 32'd0);
      end else begin
        checkOutput("held/done2", {31'd0, bus4.done}, 32'd1);
        checkOutput("held/result2", {28'd0, bus4.result}, 32'h7);
        checkOutput("held/cout2", {31'd0, bus4.cout}, 32'd1);
        checkOutput("held/ovf2", {31'd0, bus4.ovf}, 32'd1);
      end
    end
    @(posedge clk); #1;

    // Reset asserted in the second RUN cycle clears everything at once.
    applyStimulus(1'b0, 4'h5, 4'h3);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #2;
    checkOutput("rst/busyBefore", {31'd0, bus4.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst/busy", {31'd0, bus4.busy}, 32'd0);
    checkOutput("rst/done", {31'd0, bus4.done}, 32'd0);
    checkOutput("rst/result", {28'd0, bus4.result}, 32'd0);
    checkOutput("rst/cout", {31'd0, bus4.cout}, 32'd0);
    checkOutput("rst/ovf", {31'd0, bus4.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("rst/discarded", {31'd0, bus4.done}, 32'd0);
    end
    run4("add7p7", 1'b0, 4'h7, 4'h7, 4'hE, 1'b0, 1'b1);

    // Every 4-bit operand/op combination against the reference.
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          e = model(4, op[0], a, b);
          run4("sweep4", op[0], 4'(a), 4'(b), e[3:0], e[4], e[5]);
        end
      end
    end

    // 8-bit instance: hand-computed edges, then random operands.
    run8("add7Fp01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run8("sub00m01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
    run8("sub80m01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 1'($urandom_range(0, 1));
      e   = model(8, rop, {24'd0, ra}, {24'd0, rb});
      run8("rand8", rop, ra, rb, e[7:0], e[8], e[9]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
